stage_fifo: RTL and testbench
=============================

# stage_fifo

Parametrised elastic stage buffer for the pipeline's inter-stage valid/ready buses (F→D, D→X, X→M, M→W). It is a DEPTH-entry FIFO of WIDTH-bit payload words with a valid/ready handshake on each side. It adds a synchronous flush for squashing in-flight instructions on redirect or trap, plus an optional ready-passthrough mode, so DEPTH=1 still sustains one transfer per cycle. Stage payload structs are packed into `s_data`/`m_data` by the surrounding stage.

## Interface

Parameters:
- `WIDTH`, default 32: payload width in bits; must be ≥ 1.
- `DEPTH`, default 2: number of entries; must be ≥ 1; need not be a power of two.
- `READY_PASS`, default 0:
  - 1: `s_ready` may depend combinationally on `m_ready` (push into a full buffer while popping).
  - 0: `s_ready` depends only on registered state.
- `CW`, default $clog2(DEPTH+1): width of `count`; derived, not overridden.

Ports:
- `clk` in 1: the single clock; all state updates on the posedge.
- `rst` in 1: synchronous, active-low reset.
- `flush` in 1: synchronous; discards all entries.
- `s_valid` in 1: upstream offers `s_data`.
- `s_ready` out 1: buffer accepts this cycle.
- `s_data` in WIDTH: upstream payload.
- `m_valid` out 1: head entry present.
- `m_ready` in 1: downstream consumes the head.
- `m_data` out WIDTH: head payload.
- `count` out CW: occupied entries, 0..DEPTH.

## Operation

- **Storage and pointers**
  - Storage: DEPTH registers, read pointer `rp` and write pointer `wp`.
  - Each pointer increments modulo DEPTH, wrapping DEPTH-1→0 explicitly (no reliance on power-of-two overflow).
  - `count` is a registered occupancy counter.
- **Transfer conditions**
  - push = `s_valid & s_ready`.
  - pop = `m_valid & m_ready`.
- **Per-cycle update (rst high, flush low)**
  - push only: write `s_data` at `wp`, advance `wp`, count+1.
  - pop only: advance `rp`, count-1.
  - push and pop together: both pointers advance, count unchanged. Legal at any count when READY_PASS=1; at count<DEPTH otherwise.
- **Output logic**
  - `m_valid` = (count != 0).
  - `m_data` = storage[`rp`].
  - `full` = (count == DEPTH).
  - READY_PASS=0: `s_ready` = ~full.
  - READY_PASS=1: `s_ready` = ~full | m_ready.
  - `s_ready` is forced 0 while rst is low.
- **Flush**
  - Next state: `rp`=`wp`=0, count=0.
  - Any push or pop offered in the flush cycle is ignored: the word is not stored and no pop is counted.
  - Storage contents are not cleared; `m_data` is don't-care while `m_valid`=0.
  - `s_ready` in the flush cycle follows the normal equation. Upstream must treat its own flush as dropping the word.
- **Reset**
  - Next state: `rp`=`wp`=0, count=0, all storage words = 0.
  - Reset has priority over flush, push and pop, and aborts any in-progress contents mid-stream.
- **Handshake rules**
  - Once `m_valid` rises, `m_valid` and `m_data` are held stable until pop, flush or reset.
  - The upstream side obeys the same rule. The block does not check this; the bench asserts it.
- **Invariants and overflow protection**
  - count never exceeds DEPTH and never underflows.
  - Both are structurally impossible given the push/pop gating.

## Timing

- Latency: a word pushed at edge N appears on `m_data` with `m_valid`=1 after edge N; it can be popped at edge N+1 at the earliest. There is no empty-bypass path.
- Throughput: one word per cycle sustained when DEPTH≥2, or when DEPTH=1 with READY_PASS=1.
  - DEPTH=1 with READY_PASS=0 gives 50% throughput.
- Combinational paths:
  - READY_PASS=1: `m_ready`→`s_ready` only.
  - No `s_valid`→`m_valid` path and no `s_data`→`m_data` path in any mode.
- Post-reset values (first cycle with rst high): `m_valid`=0, `m_data`=0, `count`=0, `s_ready`=1.
- After flush, the next cycle shows `m_valid`=0, `count`=0, and `s_ready`=1.

## Test plan

- **Reset:** hold rst=0 for 3 cycles with s_valid=1 and s_data=32'hDEAD_BEEF, then release → s_ready=0 during reset; afterwards m_valid=0, count=0, m_data=0, and nothing is captured.
- **Fill and drain, DEPTH=2, READY_PASS=0:**
  - Push 32'h1, 32'h2, 32'h3 on consecutive cycles with m_ready=0 → count=2, s_ready=0, the third word is held upstream.
  - Raise m_ready → pops return 1, 2, 3 in order; count returns to 0.
- **Streaming, DEPTH=1, READY_PASS=1:** 8 back-to-back words 0..7 with m_ready=1 → one pop per cycle, values 0..7 in order, count toggles only between 0 and 1.
- **Wrap-around, DEPTH=3:** 10 words with m_ready randomly toggled → output order matches input, pointers wrap 2→0 without loss or duplication, count always ≤ 3.
- **Flush with simultaneous push, DEPTH=2:**
  - Hold 2 entries, then assert flush together with s_valid=1 and s_data=32'hAA → next cycle count=0 and m_valid=0; 32'hAA never appears.
  - A subsequent push of 32'h55 emerges as the first output.
- **Backpressure stability:** with m_ready=0 for 5 cycles while count>0 → m_data and m_valid remain constant every cycle.

Source files
------------

// File: rtl/stage_fifo.sv
// Elastic valid/ready stage buffer: DEPTH-entry FIFO with synchronous flush
// and optional combinational ready passthrough for full-rate DEPTH=1 stages.
module stage_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 2,
  parameter bit READY_PASS = 1'b0,
  parameter int CW         = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rp;
  logic [PW-1:0]    r_wp;
  logic [CW-1:0]    r_count;

  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_rp_nxt;
  logic [PW-1:0]    w_wp_nxt;

  assign w_full  = (r_count == FULL_CNT);
  assign m_valid = (r_count != '0);
  assign m_data  = r_mem[r_rp];
  assign count   = r_count;

  // Passthrough lets a full buffer accept a word in the same cycle its head leaves.
  assign s_ready = rst & (~w_full | (READY_PASS & m_ready));

  assign w_push = s_valid & s_ready;
  assign w_pop  = m_valid & m_ready;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  assign w_rp_nxt = (r_rp == LAST_IDX) ? '0 : r_rp + 1'b1;
  assign w_wp_nxt = (r_wp == LAST_IDX) ? '0 : r_wp + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rp    <= '0;
      r_wp    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_rp    <= '0;
      r_wp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= s_data;
        r_wp        <= w_wp_nxt;
      end
      if (w_pop) begin
        r_rp <= w_rp_nxt;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_fifo.sv
// Scoreboard bench for stage_fifo: three configurations share one clock; a
// queue per instance models the buffer and a negedge monitor checks outputs.
module tb_stage_fifo;

  localparam int N = 3;
  localparam int DEP [N] = '{2, 1, 3};
  localparam bit RPS [N] = '{1'b0, 1'b1, 1'b0};

  logic        clk;
  logic        rst;
  logic        fl  [N];
  logic        sv  [N];
  logic        sr  [N];
  logic [31:0] sd  [N];
  logic        mv  [N];
  logic        mr  [N];
  logic [31:0] md  [N];
  logic [1:0]  cnt [N];

  logic [31:0] q [N][$];
  bit          zero_exp [N];
  int          vec;
  int          mis;
  bit          done2;
  bit          rdone;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int CWG = $clog2(DEP[g] + 1);
    logic [CWG-1:0] w_cnt;
    stage_fifo #(.WIDTH(32), .DEPTH(DEP[g]), .READY_PASS(RPS[g])) u_dut (
      .clk(clk), .rst(rst), .flush(fl[g]),
      .s_valid(sv[g]), .s_ready(sr[g]), .s_data(sd[g]),
      .m_valid(mv[g]), .m_ready(mr[g]), .m_data(md[g]),
      .count(w_cnt)
    );
    assign cnt[g] = 2'(w_cnt);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s[inst%0d] t=%0t: got %h, expected %h", nm, i, $time, act, exp);
    end
  endtask

  // Output monitor and reference model; inputs seen here are those the next posedge samples.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      int   sz;
      logic er;
      sz = q[i].size();
      er = rst && ((sz < DEP[i]) || (RPS[i] && mr[i]));
      chk("s_ready", i, 32'(sr[i]), 32'(er));
      if (rst) begin
        chk("m_valid", i, 32'(mv[i]), 32'(sz != 0));
        chk("count", i, 32'(cnt[i]), 32'(sz));
        if (sz != 0) chk("m_data", i, md[i], q[i][0]);
        else if (zero_exp[i]) chk("m_data_reset", i, md[i], 32'h0);
      end
      if (!rst) begin
        q[i].delete();
        zero_exp[i] = 1'b1;
      end else if (fl[i]) begin
        q[i].delete();
        zero_exp[i] = 1'b0;
      end else begin
        if (sz != 0 && mr[i]) void'(q[i].pop_front());
        if (sv[i] && er) begin
          q[i].push_back(sd[i]);
          zero_exp[i] = 1'b0;
        end
      end
    end
  end

  // Hold a word until accepted; returns to the caller at posedge+1 with s_valid low.
  task automatic send(input int i, input logic [31:0] d, output int waits);
    sv[i] = 1'b1;
    sd[i] = d;
    waits = 0;
    while (1) begin
      @(negedge clk);
      if (sr[i]) break;
      waits++;
      if (waits >= 200) begin
        vec++;
        mis++;
        $display("FAIL send_timeout[inst%0d]: got no s_ready, expected acceptance within 200 cycles", i);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    sv[i] = 1'b0;
  endtask

  task automatic rand_traffic(input int i);
    int w;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        fl[i] = 1'b1;
        @(posedge clk);
        #1;
        fl[i] = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        send(i, $urandom, w);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    logic [31:0] d0;
    vec = 0;
    mis = 0;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      fl[i] = 1'b0;
      sv[i] = 1'b1;
      sd[i] = 32'hDEAD_BEEF;
      mr[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < N; i++) sv[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // fill and drain, DEPTH=2 READY_PASS=0
    send(0, 32'h1, w);
    send(0, 32'h2, w);
    fork
      begin
        send(0, 32'h3, w);
        chk("third_held", 0, 32'(w >= 3), 32'h1);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        mr[0] = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drain_count", 0, 32'(cnt[0]), 32'h0);
    @(posedge clk);
    #1;
    mr[0] = 1'b0;

    // streaming, DEPTH=1 READY_PASS=1
    mr[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      send(1, 32'(k), w);
      chk("stream_stall", 1, 32'(w), 32'h0);
    end
    repeat (2) @(posedge clk);
    #1;
    mr[1] = 1'b0;

    // wrap-around, DEPTH=3, random downstream readiness
    done2 = 1'b0;
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          repeat ($urandom_range(0, 1)) begin
            @(posedge clk);
            #1;
          end
          send(2, $urandom, w);
        end
        done2 = 1'b1;
      end
      begin
        while (!done2) begin
          @(posedge clk);
          #1;
          mr[2] = 1'($urandom_range(0, 1));
        end
        mr[2] = 1'b1;
      end
    join
    repeat (5) @(posedge clk);
    #1;
    mr[2] = 1'b0;

    // flush with simultaneous push
    send(0, 32'h11, w);
    send(0, 32'h22, w);
    fl[0] = 1'b1;
    sv[0] = 1'b1;
    sd[0] = 32'hAA;
    @(posedge clk);
    #1;
    fl[0] = 1'b0;
    sv[0] = 1'b0;
    @(negedge clk);
    chk("flush_count", 0, 32'(cnt[0]), 32'h0);
    chk("flush_m_valid", 0, 32'(mv[0]), 32'h0);
    chk("flush_s_ready", 0, 32'(sr[0]), 32'h1);
    @(posedge clk);
    #1;
    mr[0] = 1'b1;
    send(0, 32'h55, w);
    repeat (3) @(posedge clk);
    #1;

    // backpressure stability
    mr[0] = 1'b0;
    d0 = $urandom;
    send(0, d0, w);
    send(0, $urandom, w);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_m_valid", 0, 32'(mv[0]), 32'h1);
      chk("hold_m_data", 0, md[0], d0);
    end
    @(posedge clk);
    #1;
    mr[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // mixed random traffic with occasional flushes on all instances
    rdone = 1'b0;
    fork
      begin
        fork
          rand_traffic(0);
          rand_traffic(1);
          rand_traffic(2);
        join
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1;
          for (int i = 0; i < N; i++) mr[i] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < N; i++) mr[i] = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) chk("final_count", i, 32'(cnt[i]), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
